// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: MDU stall FSM states,
// forwarding-select encodings and the forwarding priority helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mduState_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwdSel_t;

   // Picks the operand source for one E-stage source register. The M result
   // is younger than the W result, so it wins when both match. Register x0
   // is hardwired to zero and is never forwarded.
   function automatic fwdSel_t fwdSelect(input logic [4:0] rs,
                                         input logic [4:0] rdM,
                                         input logic       regWriteM,
                                         input logic [4:0] rdW,
                                         input logic       regWriteW);
      fwdSel_t sel;
      sel = FWD_RF;
      if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
         sel = FWD_M;
      end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-facing signals seen by the hazard controller. The
// pipeline datapath is the master; the hazard controller is the slave.
interface hazard_ctrl_if;

   logic [4:0] rs1D;
   logic [4:0] rs2D;
   logic [4:0] rs1E;
   logic [4:0] rs2E;
   logic [4:0] rdE;
   logic       memReadE;
   logic       pcSrcE;
   logic       mduStartE;
   logic [4:0] rdM;
   logic [4:0] rdW;
   logic       regWriteM;
   logic       regWriteW;
   logic       dmemReadyM;

   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       stallM;
   logic       flushD;
   logic       flushE;
   logic       flushM;
   logic       flushW;
   logic [1:0] forwardAE;
   logic [1:0] forwardBE;
   logic       mduBusy;

   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcSrcE, mduStartE,
             rdM, rdW, regWriteM, regWriteW, dmemReadyM,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
             forwardAE, forwardBE, mduBusy
   );

   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcSrcE, mduStartE,
             rdM, rdW, regWriteM, regWriteW, dmemReadyM,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
             forwardAE, forwardBE, mduBusy
   );

endinterface

// File: rtl/mdu_stall_fsm.sv
// Multicycle (mul/div) stall sequencer. Stalls the op in E for CYCLES cycles,
// then spends one DONE cycle letting it advance. 'hold' freezes everything
// while an outstanding memory access stalls the whole pipe.
module mdu_stall_fsm
   import hazard_pkg::*;
#(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic hold,
   output logic busy,
   output logic done
);

   localparam int CW = $clog2(CYCLES);

   mduState_t     state_q, state_d;
   logic [CW-1:0] count_q, count_d;

   // State and countdown registers, cleared by synchronous reset at any point.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next state and stall outputs; the start cycle itself already stalls, so
   // the counter is loaded with CYCLES-1 remaining BUSY cycles.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               busy = 1'b1;
               if (!hold) begin
                  state_d = BUSY;
                  count_d = CW'(CYCLES - 1);
               end
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (!hold) begin
               if (count_q == CW'(1)) begin
                  state_d = DONE;
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (!hold) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding into E plus prioritised
// stall/flush generation for memory waits, multicycle ops, taken branches
// and load-use hazards.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     bus
);

   logic fsmBusy;
   logic fsmDone;
   logic mduStall;
   logic memStall;
   logic loadUse;

   mdu_stall_fsm #(.CYCLES(MDU_CYCLES)) u_fsm (
      .clk   (clk),
      .reset (reset),
      .start (bus.mduStartE),
      .hold  (memStall),
      .busy  (fsmBusy),
      .done  (fsmDone)
   );

   // Hazard detection terms; DONE is the release cycle and never stalls.
   always_comb begin
      memStall = !bus.dmemReadyM;
      mduStall = fsmBusy && !fsmDone;
      loadUse  = bus.memReadE && (bus.rdE != 5'd0) &&
                 ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));
   end

   // Stall/flush resolution in priority order, all zero while in reset.
   always_comb begin
      bus.stallF  = 1'b0;
      bus.stallD  = 1'b0;
      bus.stallE  = 1'b0;
      bus.stallM  = 1'b0;
      bus.flushD  = 1'b0;
      bus.flushE  = 1'b0;
      bus.flushM  = 1'b0;
      bus.flushW  = 1'b0;
      bus.mduBusy = 1'b0;
      if (!reset) begin
         bus.mduBusy = mduStall;
         if (memStall) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            bus.stallM = 1'b1;
            bus.flushW = 1'b1;
         end else if (mduStall) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            bus.flushM = 1'b1;
         end else if (bus.pcSrcE) begin
            bus.flushD = 1'b1;
            bus.flushE = 1'b1;
         end else if (loadUse) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.flushE = 1'b1;
         end
      end
   end

   // Operand forwarding for both E-stage sources, forced to regfile in reset.
   always_comb begin
      bus.forwardAE = FWD_RF;
      bus.forwardBE = FWD_RF;
      if (!reset) begin
         bus.forwardAE = fwdSelect(bus.rs1E, bus.rdM, bus.regWriteM,
                                   bus.rdW, bus.regWriteW);
         bus.forwardBE = fwdSelect(bus.rs2E, bus.rdM, bus.regWriteM,
                                   bus.rdW, bus.regWriteW);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MDU_CYCLES = 4.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   // Control vector layout: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,mduBusy}
   localparam logic [8:0] CTRL_NONE   = 9'b000000000;
   localparam logic [8:0] CTRL_MDU    = 9'b111000101;
   localparam logic [8:0] CTRL_MEM    = 9'b111100010;
   localparam logic [8:0] CTRL_MEMMDU = 9'b111100011;
   localparam logic [8:0] CTRL_LU     = 9'b110001000;
   localparam logic [8:0] CTRL_BR     = 9'b000011000;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hazard_ctrl_if bus ();

   hazard_ctrl #(.MDU_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [8:0] ctrlVec();
      return {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
              bus.flushD, bus.flushE, bus.flushM, bus.flushW, bus.mduBusy};
   endfunction

   task automatic applyStimulus();
      bus.rs1D       = 5'd0;
      bus.rs2D       = 5'd0;
      bus.rs1E       = 5'd0;
      bus.rs2E       = 5'd0;
      bus.rdE        = 5'd0;
      bus.memReadE   = 1'b0;
      bus.pcSrcE     = 1'b0;
      bus.mduStartE  = 1'b0;
      bus.rdM        = 5'd0;
      bus.rdW        = 5'd0;
      bus.regWriteM  = 1'b0;
      bus.regWriteW  = 1'b0;
      bus.dmemReadyM = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      applyStimulus();

      // Reset dominates every hazard source.
      bus.dmemReadyM = 1'b0;
      bus.mduStartE  = 1'b1;
      bus.pcSrcE     = 1'b1;
      bus.rdM = 5'd5; bus.regWriteM = 1'b1; bus.rs1E = 5'd5;
      #1;
      checkOutput("reset_ctrl", 32'(ctrlVec()), 32'(CTRL_NONE));
      checkOutput("reset_fwdA", 32'(bus.forwardAE), 32'(2'b00));
      tick();
      tick();
      checkOutput("reset_state", 32'(dut.u_fsm.state_q), 32'(IDLE));
      reset = 1'b0;
      applyStimulus();
      #1;
      checkOutput("idle_ctrl", 32'(ctrlVec()), 32'(CTRL_NONE));

      // Forwarding: M beats W, x0 never forwarded, W used when M not writing.
      bus.rdM = 5'd5; bus.regWriteM = 1'b1; bus.rdW = 5'd5; bus.regWriteW = 1'b1;
      bus.rs1E = 5'd5; bus.rs2E = 5'd5;
      #1;
      checkOutput("fwd_MoverW_A", 32'(bus.forwardAE), 32'(2'b10));
      checkOutput("fwd_MoverW_B", 32'(bus.forwardBE), 32'(2'b10));
      bus.rdM = 5'd0; bus.rdW = 5'd0; bus.rs1E = 5'd0; bus.rs2E = 5'd0;
      #1;
      checkOutput("fwd_x0_A", 32'(bus.forwardAE), 32'(2'b00));
      bus.rdM = 5'd3; bus.rdW = 5'd6; bus.rs1E = 5'd3; bus.rs2E = 5'd6;
      #1;
      checkOutput("fwd_split_A", 32'(bus.forwardAE), 32'(2'b10));
      checkOutput("fwd_split_B", 32'(bus.forwardBE), 32'(2'b01));
      bus.regWriteM = 1'b0; bus.rdW = 5'd3;
      #1;
      checkOutput("fwd_noWrM_A", 32'(bus.forwardAE), 32'(2'b01));
      checkOutput("fwd_noWrM_B", 32'(bus.forwardBE), 32'(2'b00));
      applyStimulus();

      // Load-use: one bubble, gone once the load leaves E.
      bus.memReadE = 1'b1; bus.rdE = 5'd7; bus.rs2D = 5'd7;
      #1;
      checkOutput("lu_stall", 32'(ctrlVec()), 32'(CTRL_LU));
      tick();
      bus.memReadE = 1'b0; bus.rdE = 5'd0;
      #1;
      checkOutput("lu_release", 32'(ctrlVec()), 32'(CTRL_NONE));
      bus.memReadE = 1'b1; bus.rdE = 5'd0; bus.rs1D = 5'd0;
      #1;
      checkOutput("lu_x0", 32'(ctrlVec()), 32'(CTRL_NONE));

      // Branch beats load-use.
      bus.rdE = 5'd7; bus.rs2D = 5'd7; bus.pcSrcE = 1'b1;
      #1;
      checkOutput("br_over_lu", 32'(ctrlVec()), 32'(CTRL_BR));
      applyStimulus();

      // Memory stall beats branch, no MDU activity.
      bus.dmemReadyM = 1'b0; bus.pcSrcE = 1'b1;
      #1;
      checkOutput("mem_over_br", 32'(ctrlVec()), 32'(CTRL_MEM));
      tick();
      applyStimulus();

      // MDU op: exactly 4 stall cycles, then a DONE cycle, then IDLE.
      bus.mduStartE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("mdu_stall_%0d", i), 32'(ctrlVec()), 32'(CTRL_MDU));
         tick();
      end
      checkOutput("mdu_done", 32'(ctrlVec()), 32'(CTRL_NONE));
      tick();
      bus.mduStartE = 1'b0;
      #1;
      checkOutput("mdu_idle_state", 32'(dut.u_fsm.state_q), 32'(IDLE));
      checkOutput("mdu_idle_ctrl", 32'(ctrlVec()), 32'(CTRL_NONE));

      // MDU op with a 3-cycle memory stall while the counter sits at 2.
      bus.mduStartE = 1'b1;
      #1;
      checkOutput("mduh_start", 32'(ctrlVec()), 32'(CTRL_MDU));
      tick();
      checkOutput("mduh_busy3", 32'(ctrlVec()), 32'(CTRL_MDU));
      tick();
      checkOutput("mduh_cnt2", 32'(dut.u_fsm.count_q), 32'd2);
      bus.dmemReadyM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("mduh_mem_%0d", i), 32'(ctrlVec()), 32'(CTRL_MEMMDU));
         tick();
      end
      bus.dmemReadyM = 1'b1;
      #1;
      checkOutput("mduh_cnt_held", 32'(dut.u_fsm.count_q), 32'd2);
      checkOutput("mduh_busy2", 32'(ctrlVec()), 32'(CTRL_MDU));
      tick();
      checkOutput("mduh_busy1", 32'(ctrlVec()), 32'(CTRL_MDU));
      tick();
      checkOutput("mduh_done", 32'(ctrlVec()), 32'(CTRL_NONE));
      tick();
      applyStimulus();

      // Reset mid-BUSY, then a fresh op gets the full stall.
      bus.mduStartE = 1'b1;
      tick();
      tick();
      checkOutput("rst_busy_state", 32'(dut.u_fsm.state_q), 32'(BUSY));
      reset = 1'b1;
      #1;
      checkOutput("rst_busy_ctrl", 32'(ctrlVec()), 32'(CTRL_NONE));
      tick();
      reset = 1'b0;
      bus.mduStartE = 1'b0;
      #1;
      checkOutput("rst_after_state", 32'(dut.u_fsm.state_q), 32'(IDLE));
      checkOutput("rst_after_ctrl", 32'(ctrlVec()), 32'(CTRL_NONE));
      tick();
      bus.mduStartE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("rst_restart_%0d", i), 32'(ctrlVec()), 32'(CTRL_MDU));
         tick();
      end
      checkOutput("rst_restart_done", 32'(ctrlVec()), 32'(CTRL_NONE));
      tick();
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MDU_CYCLES, default 4, number of stall cycles for a multicycle (mul/div) op in E; legal range >= 2.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rs1D, rs2D  input  5 each  source registers of instruction in D.
REQ-005 rs1E, rs2E, rdE  input  5 each  sources/destination of instruction in E.
REQ-006 memReadE  input  1  instruction in E is a load.
REQ-007 pcSrcE  input  1  taken branch/jump resolved in E.
REQ-008 mduStartE  input  1  instruction in E is a multicycle op; held high while it sits in E.
REQ-009 rdM, rdW  input  5 each; regWriteM, regWriteW  input  1 each  writeback info of M/W instructions.
REQ-010 dmemReadyM  input  1  data memory ready; 0 = M access outstanding.
REQ-011 stallF, stallD, stallE, stallM  output  1 each  hold pipeline register of that stage.
REQ-012 flushD, flushE, flushM, flushW  output  1 each  clear pipeline register of that stage (bubble).
REQ-013 forwardAE, forwardBE  output  2 each  operand source for rs1E/rs2E: 00 regfile, 01 W result, 10 M result.
REQ-014 mduBusy  output  1  MDU stall in progress.

Function
REQ-015 Forwarding (combinational): forwardAE = 10 if regWriteM & rdM!=0 & rdM==rs1E; else 01 if regWriteW & rdW!=0 & rdW==rs1E; else 00; forwardBE identical using rs2E; M beats W.
REQ-016 Memory stall (dmemReadyM=0): stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=flushM=0; overrides all other conditions; MDU FSM state and counter hold.
REQ-017 MDU FSM states IDLE, BUSY, DONE; counter width $clog2(MDU_CYCLES).
REQ-018 IDLE & mduStartE: stallF/D/E=1, flushM=1, mduBusy=1; next state BUSY, counter loaded MDU_CYCLES-1.
REQ-019 BUSY: stallF/D/E=1, flushM=1, mduBusy=1; counter==1 -> DONE, else decrement.
REQ-020 DONE: no MDU stall; mduStartE ignored; next state IDLE unconditionally; the op advances to M this cycle.
REQ-021 Net result: MDU op stalls exactly MDU_CYCLES cycles and occupies E for MDU_CYCLES+1 cycles.
REQ-022 Load-use (no memory/MDU stall): memReadE & rdE!=0 & (rdE==rs1D | rdE==rs2D) -> stallF=stallD=1, flushE=1; exactly one bubble.
REQ-023 Branch (no memory/MDU stall): pcSrcE -> flushD=flushE=1; overrides load-use (stallF=stallD=0 that cycle).
REQ-024 Priority: reset > memory stall > MDU stall > branch flush > load-use.
REQ-025 All stall/flush outputs are combinational from inputs and FSM state; no added latency.

Reset
REQ-026 reset=1 at a clock edge: FSM -> IDLE, counter -> 0, regardless of current state (including mid-BUSY).
REQ-027 While reset=1: all stall/flush outputs and mduBusy = 0; forwardAE/BE = 00.

Structure
REQ-028 Shared package hazard_pkg holds the MDU state enum (IDLE, BUSY, DONE) and forwarding-select enum (FWD_RF=00, FWD_W=01, FWD_M=10).
REQ-029 MDU FSM + counter in one sub-module mdu_stall_fsm (inputs start, hold; outputs busy, done); hazard_ctrl adds forwarding and priority logic.

Verification
REQ-030 rdM=5, regWriteM=1, rdW=5, regWriteW=1, rs1E=5 -> forwardAE=10; rdM=0, rs1E=0 -> 00.
REQ-031 memReadE=1, rdE=7, rs2D=7 -> one cycle stallF=stallD=flushE=1, then all 0 once load leaves E.
REQ-032 mduStartE held, MDU_CYCLES=4 -> mduBusy/stallE high exactly 4 cycles, op in E 5 cycles, FSM back to IDLE.
REQ-033 dmemReadyM=0 for 3 cycles during BUSY (counter=2) -> stallF..M=1, flushW=1, counter still 2 afterward, total MDU stall = 4 + 3.
REQ-034 pcSrcE=1 with simultaneous load-use hazard -> flushD=flushE=1, stallF=stallD=0.
REQ-035 reset asserted in BUSY -> next cycle IDLE, all outputs 0; new mduStartE restarts full 4-cycle stall.
